// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the read FSM state type, the default geometry/latency constants and
// the byte-lane count that goes with the default data width.
package dmem_pkg;

   localparam int DMEM_DATA_WIDTH  = 32;
   localparam int DMEM_DEPTH_WORDS = 1024;
   localparam int DMEM_RD_LAT      = 1;
   localparam int DMEM_LANES       = DMEM_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } rd_state_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised storage with a byte-strobed synchronous write port and a
// combinational read port. Contents are deliberately not reset.
// Ports:
//   mem_clk    clock
//   wr_en      write enable (already qualified as in range by the caller)
//   wr_idx     word index of the write
//   wr_data    write data, lane aligned
//   wr_strobe  per-byte-lane write enables
//   rd_idx     word index of the read
//   rd_data    current word contents at rd_idx
module dmem_sram_array
   import dmem_pkg::*;
#(
   parameter  int DATA_WIDTH  = DMEM_DATA_WIDTH,
   parameter  int DEPTH_WORDS = DMEM_DEPTH_WORDS,
   localparam int LANES       = DATA_WIDTH / 8,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  mem_clk,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [LANES-1:0]      wr_strobe,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge mem_clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wr_strobe[i]) begin
               mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: byte-strobed writes that commit every cycle, and a
// read path with a programmable latency of RD_LAT cycles from accept to
// data_mem_read_valid. Out-of-range accesses raise a one-cycle mem_err.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no read outstanding, accepting requests
//   WAIT  | read accepted, latency counter running, read_en ignored
//   RESP  | read data valid this cycle, a new request may be accepted
//
// Ports:
//   mem_clk / mem_rst        clock, async active-low reset
//   data_mem_write_*         write request, byte address, data, lane strobes
//   data_mem_read_en/addr    read request and byte address
//   data_mem_read_data       full-word read data, held outside RESP
//   data_mem_read_valid      high exactly in RESP
//   mem_stall                high exactly in WAIT
//   mem_err                  one-cycle pulse on an out-of-range access
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter  int DATA_WIDTH  = DMEM_DATA_WIDTH,
   parameter  int DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter  int RD_LAT      = DMEM_RD_LAT,
   localparam int LANES       = DATA_WIDTH / 8
) (
   input  logic                  mem_clk,
   input  logic                  mem_rst,
   input  logic                  data_mem_write_en,
   input  logic [DATA_WIDTH-1:0] data_mem_write_addr,
   input  logic [DATA_WIDTH-1:0] data_mem_write_data,
   input  logic [LANES-1:0]      data_mem_strobe,
   input  logic                  data_mem_read_en,
   input  logic [DATA_WIDTH-1:0] data_mem_read_addr,
   output logic [DATA_WIDTH-1:0] data_mem_read_data,
   output logic                  data_mem_read_valid,
   output logic                  mem_stall,
   output logic                  mem_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = 2;

   rd_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  err_q;

   logic                  wr_in_range, wr_ok, wr_oob;
   logic                  accept, enter_resp;
   logic [DATA_WIDTH-1:0] rd_sel_addr;
   logic                  rd_in_range;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] sram_word, fwd_word, rd_word;
   logic                  unused_addr_lsbs;

   // In range means every bit above the word index is zero.
   assign wr_in_range = (data_mem_write_addr[DATA_WIDTH-1:IDX_W+2] == '0);
   assign wr_ok       = data_mem_write_en && wr_in_range;
   assign wr_oob      = data_mem_write_en && !wr_in_range;
   assign wr_idx      = data_mem_write_addr[IDX_W+1:2];

   assign accept = data_mem_read_en && (state_q != WAIT);

   // The edge entering RESP reads either the latched address (leaving WAIT)
   // or the request on the bus (RD_LAT=1 accept, which enters RESP directly).
   assign rd_sel_addr = (state_q == WAIT) ? addr_q : data_mem_read_addr;
   assign rd_in_range = (rd_sel_addr[DATA_WIDTH-1:IDX_W+2] == '0);
   assign rd_idx      = rd_sel_addr[IDX_W+1:2];

   // Byte lanes are selected by the strobe, so the low address bits carry no meaning.
   assign unused_addr_lsbs = ^{data_mem_write_addr[1:0], rd_sel_addr[1:0]};

   dmem_sram_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .mem_clk   (mem_clk),
      .wr_en     (wr_ok),
      .wr_idx    (wr_idx),
      .wr_data   (data_mem_write_data),
      .wr_strobe (data_mem_strobe),
      .rd_idx    (rd_idx),
      .rd_data   (sram_word)
   );

   // Write-first: a write landing on the read word in the same edge wins per lane.
   always_comb begin
      fwd_word = sram_word;
      for (int i = 0; i < LANES; i++) begin
         if (wr_ok && (wr_idx == rd_idx) && data_mem_strobe[i]) begin
            fwd_word[i*8 +: 8] = data_mem_write_data[i*8 +: 8];
         end
      end
   end

   assign rd_word = rd_in_range ? fwd_word : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (data_mem_read_en) begin
               if (RD_LAT == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(RD_LAT - 2);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= data_mem_read_addr;
         end
         if (enter_resp) begin
            rd_data_q <= rd_word;
         end
         // Write and read errors share one flop, so coincident errors give one pulse.
         err_q <= wr_oob || (enter_resp && !rd_in_range);
      end
   end

   assign data_mem_read_data  = rd_data_q;
   assign data_mem_read_valid = (state_q == RESP);
   assign mem_stall           = (state_q == WAIT);
   assign mem_err             = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances with RD_LAT=1..4 share one
// stimulus stream. A behavioural model (word array plus per-instance pending
// read countdown) predicts valid, stall, err and data after every edge.
module tb_data_mem_responder;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int NI    = 4;
   localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

   logic mem_clk = 1'b0;
   logic mem_rst = 1'b0;
   always #5 mem_clk = ~mem_clk;

   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] waddr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] raddr = '0;
   logic [3:0]  strb = '0;

   logic [31:0]   rdata [NI];
   logic [NI-1:0] valid, stall, err;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_mem_responder #(
         .DATA_WIDTH  (DW),
         .DEPTH_WORDS (DEPTH),
         .RD_LAT      (g + 1)
      ) u_dut (
         .mem_clk             (mem_clk),
         .mem_rst             (mem_rst),
         .data_mem_write_en   (we),
         .data_mem_write_addr (waddr),
         .data_mem_write_data (wdata),
         .data_mem_strobe     (strb),
         .data_mem_read_en    (re),
         .data_mem_read_addr  (raddr),
         .data_mem_read_data  (rdata[g]),
         .data_mem_read_valid (valid[g]),
         .mem_stall           (stall[g]),
         .mem_err             (err[g])
      );
   end

   // reference model
   logic [31:0] mem_m [DEPTH];
   bit          pend      [NI];
   int          pend_cnt  [NI];
   logic [31:0] pend_addr [NI];
   logic [31:0] exp_data  [NI];
   bit          exp_valid [NI];
   bit          exp_stall [NI];
   bit          exp_err   [NI];

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         pend[i]      = 1'b0;
         pend_cnt[i]  = 0;
         exp_data[i]  = '0;
         exp_valid[i] = 1'b0;
         exp_stall[i] = 1'b0;
         exp_err[i]   = 1'b0;
      end
   endtask

   // One clock edge of the specified behaviour: the write lands first, so a
   // read sampled on the same edge sees it.
   task automatic model_edge();
      bit          wr_oob, samp, rd_oob;
      logic [31:0] sa;
      wr_oob = we && (waddr >= LIMIT);
      if (we && !wr_oob) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_m[waddr[11:2]][b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      for (int i = 0; i < NI; i++) begin
         samp = 1'b0;
         sa   = '0;
         if (pend[i]) begin
            pend_cnt[i]--;
            if (pend_cnt[i] == 0) begin
               samp    = 1'b1;
               sa      = pend_addr[i];
               pend[i] = 1'b0;
            end
         end else if (re) begin
            if (i == 0) begin
               samp = 1'b1;
               sa   = raddr;
            end else begin
               pend[i]      = 1'b1;
               pend_cnt[i]  = i;
               pend_addr[i] = raddr;
            end
         end
         rd_oob = samp && (sa >= LIMIT);
         if (samp) exp_data[i] = rd_oob ? 32'h0 : mem_m[sa[11:2]];
         exp_valid[i] = samp;
         exp_stall[i] = pend[i];
         exp_err[i]   = wr_oob || rd_oob;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s.valid%0d", tag, i), 32'(valid[i]), 32'(exp_valid[i]));
         chk($sformatf("%s.stall%0d", tag, i), 32'(stall[i]), 32'(exp_stall[i]));
         chk($sformatf("%s.err%0d", tag, i), 32'(err[i]), 32'(exp_err[i]));
         chk($sformatf("%s.data%0d", tag, i), rdata[i], exp_data[i]);
      end
   endtask

   task automatic step(input string tag, input logic we_i, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic re_i, input logic [31:0] ra);
      we    = we_i;
      waddr = wa;
      wdata = wd;
      strb  = st;
      re    = re_i;
      raddr = ra;
      @(posedge mem_clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step("idle", 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      else                           a = 32'($urandom_range(0, 31)) * 4;
      return a + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [31:0] w1_before;
      model_reset();
      #2;
      check_all("reset");
      @(negedge mem_clk);
      @(negedge mem_clk);
      mem_rst = 1'b1;

      // storage is not reset, so give every word a known value first
      for (int w = 0; w < DEPTH; w++) begin
         step("preload", 1'b1, 32'(w) * 4, $urandom, 4'hF, 1'b0, '0);
      end

      // full write then read at latency 1
      step("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0);
      step("rd10", 1'b0, '0, '0, '0, 1'b1, 32'h10);
      chk("lat1_valid", 32'(valid[0]), 32'd1);
      chk("lat1_data", rdata[0], 32'hDEADBEEF);
      idle(5);

      // single-lane write over the previous word
      step("wr10p", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, '0);
      step("rd10p", 1'b0, '0, '0, '0, 1'b1, 32'h10);
      chk("partial_data", rdata[0], 32'hDEADBEAA);
      idle(5);

      // latency 3 with a write landing during the wait
      step("rd20", 1'b0, '0, '0, '0, 1'b1, 32'h20);
      chk("lat3_stall_t1", 32'(stall[2]), 32'd1);
      step("wr20", 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, '0);
      chk("lat3_stall_t2", 32'(stall[2]), 32'd1);
      chk("lat3_novalid_t2", 32'(valid[2]), 32'd0);
      step("lat3_t3", 1'b0, '0, '0, '0, 1'b0, '0);
      chk("lat3_valid_t3", 32'(valid[2]), 32'd1);
      chk("lat3_data", rdata[2], 32'h12345678);
      step("lat3_t4", 1'b0, '0, '0, '0, 1'b0, '0);
      chk("lat3_valid_t4", 32'(valid[2]), 32'd0);
      idle(4);

      // latency 2 with a partial write on the edge that enters RESP
      step("wr30", 1'b1, 32'h30, 32'h11111111, 4'hF, 1'b0, '0);
      step("rd30", 1'b0, '0, '0, '0, 1'b1, 32'h30);
      step("wr30c", 1'b1, 32'h30, 32'hFF00FF00, 4'b1100, 1'b0, '0);
      chk("collide_valid", 32'(valid[1]), 32'd1);
      chk("collide_data", rdata[1], 32'hFF001111);
      idle(5);

      // out-of-range read and write
      step("rdoob", 1'b0, '0, '0, '0, 1'b1, 32'h1000);
      chk("oob_rd_valid", 32'(valid[0]), 32'd1);
      chk("oob_rd_data", rdata[0], 32'h0);
      chk("oob_rd_err", 32'(err[0]), 32'd1);
      idle(5);
      w1_before = mem_m[1];
      step("wroob", 1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, 1'b0, '0);
      chk("oob_wr_err", 32'(err[0]), 32'd1);
      step("wroob_after", 1'b0, '0, '0, '0, 1'b0, '0);
      chk("oob_wr_err_pulse", 32'(err[0]), 32'd0);
      step("rd04", 1'b0, '0, '0, '0, 1'b1, 32'h4);
      chk("oob_wr_nochange", rdata[0], w1_before);
      idle(5);
      step("bothoob", 1'b1, 32'h1004, 32'h0, 4'hF, 1'b1, 32'h1000);
      chk("both_oob_err", 32'(err[0]), 32'd1);
      step("bothoob_after", 1'b0, '0, '0, '0, 1'b0, '0);
      chk("both_oob_single", 32'(err[0]), 32'd0);
      idle(5);

      // reset while the latency-4 instance is waiting
      step("rd40", 1'b0, '0, '0, '0, 1'b1, 32'h40);
      step("rd40_w", 1'b0, '0, '0, '0, 1'b0, '0);
      #2;
      mem_rst = 1'b0;
      #1;
      model_reset();
      check_all("mid_reset");
      chk("rst_stall3", 32'(stall[3]), 32'd0);
      @(posedge mem_clk);
      @(negedge mem_clk);
      mem_rst = 1'b1;
      idle(6);
      // first edge after release accepts normally; storage survived reset
      step("post_rst_rd", 1'b0, '0, '0, '0, 1'b1, 32'h10);
      chk("post_rst_data", rdata[0], 32'hDEADBEAA);
      idle(5);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step("rand", ($urandom_range(0, 2) == 0), rand_addr(), $urandom,
              4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1), rand_addr());
      end
      idle(5);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
